// File: rtl/stream_downsizer_pkg.sv
// rtl/stream_downsizer_pkg.sv - sizing helpers shared by the stream downsizer
package stream_downsizer_pkg;

    // Number of bits needed to represent v (0 -> 0)
    function automatic int countbits(input int v);
        int n;
        int x;
        n = 0;
        x = v;
        while (x > 0) begin
            n = n + 1;
            x = x >> 1;
        end
        return n;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stream_downsizer.sv
// rtl/stream_downsizer.sv - splits each IN_WIDTH word into RATIO OUT_WIDTH chunks, flags the last
// Optional macro STREAM_DOWNSIZER_MSB_FIRST_EN selects MSB-chunk-first order (default LSB first).
module stream_downsizer
    import stream_downsizer_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_WIDTH-1:0]          in_data,
    input  logic                         in_avail,
    output logic                         in_ready,
    output logic [IN_WIDTH/RATIO-1:0]    out_data,
    output logic                         out_avail,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int OUT_WIDTH = IN_WIDTH / RATIO;
    localparam int CW        = max_int(countbits(RATIO - 1), 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    generate
        if ((IN_WIDTH % RATIO) != 0 || RATIO < 2) begin : g_bad_params
            $error("stream_downsizer: IN_WIDTH must be a multiple of RATIO and RATIO >= 2");
        end
    endgenerate

    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                in_fire, out_fire, at_last;
    logic [CW-1:0]       sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign at_last  = full_q & (cnt_q == CNT_LAST);
    assign out_fire = full_q & out_ready;
    // Accepting on the last chunk's cycle lets words stream with no bubble
    assign in_ready = ~full_q | (out_fire & at_last);
    assign in_fire  = in_avail & in_ready;

    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (out_fire) begin
            if (at_last) begin
                cnt_d  = '0;
                full_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (in_fire) begin
            hold_d = in_data;
            cnt_d  = '0;
            full_d = 1'b1;
        end
    end

`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
    assign sel = CNT_LAST - cnt_q;
`else
    assign sel = cnt_q;
`endif

    assign out_data  = hold_q[int'(sel)*OUT_WIDTH +: OUT_WIDTH];
    assign out_avail = full_q;
    assign out_last  = at_last;

endmodule

// File: tb/tb_stream_downsizer.sv
// tb/tb_stream_downsizer.sv - scoreboard bench for stream_downsizer (RATIO 4 and RATIO 3 instances)
module tb_stream_downsizer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] a_in_data;
    logic        a_in_avail, a_in_ready, a_out_avail, a_out_ready, a_out_last;
    logic [7:0]  a_out_data;

    logic [23:0] b_in_data;
    logic        b_in_avail, b_in_ready, b_out_avail, b_out_ready, b_out_last;
    logic [7:0]  b_out_data;

    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    stream_downsizer #(.IN_WIDTH(32), .RATIO(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_avail(a_in_avail), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_avail(a_out_avail), .out_ready(a_out_ready), .out_last(a_out_last)
    );

    stream_downsizer #(.IN_WIDTH(24), .RATIO(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_avail(b_in_avail), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_avail(b_out_avail), .out_ready(b_out_ready), .out_last(b_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Chunk k of a word in the order the build emits them
    function automatic logic [7:0] chunk_of(input logic [31:0] w, input int k, input int ratio);
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
        return w[(ratio-1-k)*8 +: 8];
`else
        return w[k*8 +: 8];
`endif
    endfunction

    task automatic check_and_track(input string nm, input logic avail, input logic rdy,
                                   input logic [7:0] data, input logic last,
                                   input logic in_av, input logic out_rdy,
                                   input logic [31:0] word, input int ratio,
                                   inout logic [8:0] q[$]);
        logic in_fire, out_fire;
        chk({nm, "_out_avail"}, 32'(avail), 32'(q.size() != 0));
        chk({nm, "_in_ready"}, 32'(rdy), 32'((q.size() == 0) || (out_rdy && q.size() == 1)));
        if (q.size() != 0) begin
            chk({nm, "_out_data"}, 32'(data), 32'(q[0][7:0]));
            chk({nm, "_out_last"}, 32'(last), 32'(q[0][8]));
        end
        out_fire = avail & out_rdy;
        in_fire  = in_av & rdy;
        if (out_fire && q.size() != 0) void'(q.pop_front());
        if (in_fire) begin
            for (int k = 0; k < ratio; k++) q.push_back({k == ratio - 1, chunk_of(word, k, ratio)});
        end
    endtask

    // Inputs are set at posedge+1; checks run at posedge+2, then advance one edge
    task automatic tick();
        #1;
        check_and_track("a", a_out_avail, a_in_ready, a_out_data, a_out_last,
                        a_in_avail, a_out_ready, a_in_data, 4, qa);
        check_and_track("b", b_out_avail, b_in_ready, b_out_data, b_out_last,
                        b_in_avail, b_out_ready, 32'(b_in_data), 3, qb);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        a_in_avail = 1'b0;
        b_in_avail = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_a_empty", 32'(qa.size()), 32'd0);
        chk("drain_b_empty", 32'(qb.size()), 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_data = '0; a_in_avail = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_avail = 1'b0; b_out_ready = 1'b0;
        tick();
        chk("reset_out_data", 32'(a_out_data), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word, LSB-first (or MSB-first) with last on the final chunk
        a_in_data = 32'hDDCCBBAA; a_in_avail = 1'b1; a_out_ready = 1'b1;
        tick();
        a_in_avail = 1'b0; a_in_data = 32'hXXXXXXXX;
        drain();

        // Back-to-back words, held avail/ready: continuous chunks 01..08
        a_in_data = 32'h04030201; a_in_avail = 1'b1;
        tick();
        a_in_data = 32'h08070605;
        for (int i = 0; i < 4; i++) tick();
        a_in_avail = 1'b0;
        drain();

        // Backpressure at chunk 2 for three cycles
        a_in_data = 32'hDDCCBBAA; a_in_avail = 1'b1;
        tick();
        a_in_avail = 1'b0;
        tick();
        tick();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        a_out_ready = 1'b1;
        drain();

        // Non-power-of-2 ratio: two words back to back through the RATIO=3 instance
        b_in_data = 24'h332211; b_in_avail = 1'b1; b_out_ready = 1'b1;
        tick();
        b_in_data = 24'h665544;
        for (int i = 0; i < 3; i++) tick();
        b_in_avail = 1'b0;
        drain();

        // Asynchronous reset mid-word: outputs drop without a clock edge
        a_in_data = 32'h44332211; a_in_avail = 1'b1;
        b_in_data = 24'hCCBBAA;   b_in_avail = 1'b1;
        tick();
        a_in_avail = 1'b0; b_in_avail = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_avail", 32'(a_out_avail), 32'd0);
        chk("rst_async_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_async_out_last", 32'(a_out_last), 32'd0);
        chk("rst_async_out_data", 32'(a_out_data), 32'd0);
        chk("rst_async_b_out_avail", 32'(b_out_avail), 32'd0);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        a_in_data = 32'h5A6B7C8D; a_in_avail = 1'b1;
        tick();
        a_in_avail = 1'b0;
        drain();

        // Random avail/ready traffic on both instances
        for (int i = 0; i < 80; i++) begin
            a_in_data   = $urandom;
            a_in_avail  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 3) != 0);
            b_in_data   = 24'($urandom);
            b_in_avail  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
